// File: rtl/branch_predictor_if.sv
// Fetch/execute side of the branch predictor: lookup request, registered
// prediction result, and resolved-branch update channel.
interface branch_predictor_if;
  logic        lookup_valid_i;
  logic [63:0] lookup_pc_i;
  logic        flush_i;
  logic        pred_valid_o;
  logic        pred_taken_o;
  logic [63:0] pred_target_o;
  logic        update_valid_i;
  logic [63:0] update_pc_i;
  logic        update_taken_i;
  logic [63:0] update_target_i;

  // pipeline side: issues lookups/updates, consumes predictions
  modport master (
    output lookup_valid_i, lookup_pc_i, flush_i,
    output update_valid_i, update_pc_i, update_taken_i, update_target_i,
    input  pred_valid_o, pred_taken_o, pred_target_o
  );

  // predictor side
  modport slave (
    input  lookup_valid_i, lookup_pc_i, flush_i,
    input  update_valid_i, update_pc_i, update_taken_i, update_target_i,
    output pred_valid_o, pred_taken_o, pred_target_o
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: per-entry valid/tag/target plus a 2-bit
// saturating counter. Lookups are registered (result one cycle later) and
// always see the table state from before a same-cycle update.
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8
) (
  input logic               clk,
  input logic               resetn,
  branch_predictor_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = TAG_LO + TAG_W - 1;

  // counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T
  localparam logic [1:0] CTR_RESET = 2'b01;
  localparam logic [1:0] CTR_ALLOC = 2'b10;

  logic             ent_valid  [ENTRIES];
  logic [TAG_W-1:0] ent_tag    [ENTRIES];
  logic [63:0]      ent_target [ENTRIES];
  logic [1:0]       ent_ctr    [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic             lk_taken;
  logic             lk_accept;

  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;

  // PC bits outside index/tag (and the byte offset) do not take part
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.update_pc_i[63:TAG_HI+1], bus.update_pc_i[1:0],
                            bus.lookup_pc_i[63:TAG_HI+1], bus.lookup_pc_i[1:0]};

  // lookup side reads the current (pre-update) table contents
  always_comb begin
    lk_idx    = bus.lookup_pc_i[IDX_W+1:2];
    lk_tag    = bus.lookup_pc_i[TAG_HI:TAG_LO];
    lk_hit    = ent_valid[lk_idx] && (ent_tag[lk_idx] == lk_tag);
    lk_taken  = lk_hit && ent_ctr[lk_idx][1];
    lk_accept = bus.lookup_valid_i && !bus.flush_i;
  end

  // update side hit detection
  always_comb begin
    up_idx = bus.update_pc_i[IDX_W+1:2];
    up_tag = bus.update_pc_i[TAG_HI:TAG_LO];
    up_hit = ent_valid[up_idx] && (ent_tag[up_idx] == up_tag);
  end

  // table training: hits move the counter, taken misses allocate
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ent_valid[i]  <= 1'b0;
        ent_tag[i]    <= '0;
        ent_target[i] <= '0;
        ent_ctr[i]    <= CTR_RESET;
      end
    end else if (bus.update_valid_i) begin
      if (up_hit) begin
        if (bus.update_taken_i) begin
          ent_target[up_idx] <= bus.update_target_i;
          if (ent_ctr[up_idx] != 2'b11) ent_ctr[up_idx] <= ent_ctr[up_idx] + 2'd1;
        end else if (ent_ctr[up_idx] != 2'b00) begin
          ent_ctr[up_idx] <= ent_ctr[up_idx] - 2'd1;
        end
      end else if (bus.update_taken_i) begin
        ent_valid[up_idx]  <= 1'b1;
        ent_tag[up_idx]    <= up_tag;
        ent_target[up_idx] <= bus.update_target_i;
        ent_ctr[up_idx]    <= CTR_ALLOC;
      end
    end
  end

  // registered prediction; a flushed request never reaches the output
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.pred_valid_o  <= 1'b0;
      bus.pred_taken_o  <= 1'b0;
      bus.pred_target_o <= '0;
    end else begin
      bus.pred_valid_o <= lk_accept;
      bus.pred_taken_o <= lk_accept && lk_taken;
      if (!lk_accept)
        bus.pred_target_o <= '0;
      else if (lk_taken)
        bus.pred_target_o <= ent_target[lk_idx];
      else
        bus.pred_target_o <= bus.lookup_pc_i + 64'd4;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor (ENTRIES=64, TAG_W=8:
// index = pc[7:2], tag = pc[15:8]).
module tb_branch_predictor;
  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  typedef struct packed {
    logic        taken;
    logic [63:0] target;
  } exp_t;

  exp_t exp_q[$];

  branch_predictor_if bp ();

  branch_predictor #(.ENTRIES(64), .TAG_W(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bp.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: every presented prediction must match the oldest expectation;
  // when nothing is presented the result fields must read zero
  always @(negedge clk) begin
    exp_t e;
    if (bp.pred_valid_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pred: got taken=%0b target=%h, no prediction was expected",
                 bp.pred_taken_o, bp.pred_target_o);
      end else begin
        e = exp_q.pop_front();
        if (bp.pred_taken_o !== e.taken || bp.pred_target_o !== e.target) begin
          failures++;
          $display("FAIL pred: got taken=%0b target=%h, expected taken=%0b target=%h",
                   bp.pred_taken_o, bp.pred_target_o, e.taken, e.target);
        end
      end
    end else begin
      checks++;
      if (bp.pred_valid_o !== 1'b0 || bp.pred_taken_o !== 1'b0 || bp.pred_target_o !== 64'd0) begin
        failures++;
        $display("FAIL idle_outputs: got valid=%0b taken=%0b target=%h, expected all zero",
                 bp.pred_valid_o, bp.pred_taken_o, bp.pred_target_o);
      end
    end
  end

  task automatic idle_inputs();
    bp.lookup_valid_i  = 1'b0;
    bp.lookup_pc_i     = '0;
    bp.flush_i         = 1'b0;
    bp.update_valid_i  = 1'b0;
    bp.update_pc_i     = '0;
    bp.update_taken_i  = 1'b0;
    bp.update_target_i = '0;
  endtask

  // one clock of stimulus; expectation pushed only for a non-flushed lookup
  task automatic step(input logic lv, input logic [63:0] lpc, input logic fl,
                      input logic uv, input logic [63:0] upc, input logic ut,
                      input logic [63:0] utgt, input logic et, input logic [63:0] etgt);
    exp_t e;
    bp.lookup_valid_i  = lv;
    bp.lookup_pc_i     = lpc;
    bp.flush_i         = fl;
    bp.update_valid_i  = uv;
    bp.update_pc_i     = upc;
    bp.update_taken_i  = ut;
    bp.update_target_i = utgt;
    if (lv && !fl) begin
      e.taken  = et;
      e.target = etgt;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic lookup(input logic [63:0] pc, input logic et, input logic [63:0] etgt);
    step(1'b1, pc, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, et, etgt);
  endtask

  task automatic update(input logic [63:0] pc, input logic t, input logic [63:0] tgt);
    step(1'b0, 64'd0, 1'b0, 1'b1, pc, t, tgt, 1'b0, 64'd0);
  endtask

  task automatic idle_cycle();
    step(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 64'd0);
  endtask

  // asynchronous reset pulse; outputs must drop without waiting for a clock
  task automatic pulse_reset();
    resetn = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (bp.pred_valid_o !== 1'b0 || bp.pred_taken_o !== 1'b0 || bp.pred_target_o !== 64'd0) begin
      failures++;
      $display("FAIL async_reset: got valid=%0b taken=%0b target=%h, expected all zero",
               bp.pred_valid_o, bp.pred_taken_o, bp.pred_target_o);
    end
    bp.lookup_valid_i = 1'b1;
    bp.lookup_pc_i    = 64'h1100;
    repeat (2) @(posedge clk);
    #1;
    idle_inputs();
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    idle_inputs();
    resetn = 1'b1;
    #2 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    idle_cycle();

    // cold lookup: miss, fall-through
    lookup(64'h1000, 1'b0, 64'h1004);

    // allocate on taken miss (counter 10)
    update(64'h1000, 1'b1, 64'h2000);
    lookup(64'h1000, 1'b1, 64'h2000);

    // counter walk: 10 ->01 ->00 ->01, then up to saturation
    update(64'h1000, 1'b0, 64'h0);     lookup(64'h1000, 1'b0, 64'h1004); // 01
    update(64'h1000, 1'b0, 64'h0);     lookup(64'h1000, 1'b0, 64'h1004); // 00
    update(64'h1000, 1'b1, 64'h2100);  lookup(64'h1000, 1'b0, 64'h1004); // 01
    update(64'h1000, 1'b1, 64'h2200);  lookup(64'h1000, 1'b1, 64'h2200); // 10
    update(64'h1000, 1'b1, 64'h2300);  lookup(64'h1000, 1'b1, 64'h2300); // 11
    update(64'h1000, 1'b1, 64'h2400);  lookup(64'h1000, 1'b1, 64'h2400); // 11
    update(64'h1000, 1'b1, 64'h2400);  lookup(64'h1000, 1'b1, 64'h2400); // 11
    update(64'h1000, 1'b0, 64'h9999);  lookup(64'h1000, 1'b1, 64'h2400); // 10, target kept
    update(64'h1000, 1'b0, 64'h0);     lookup(64'h1000, 1'b0, 64'h1004); // 01

    // aliasing: same index, different tag
    update(64'h1000, 1'b1, 64'h2500);  lookup(64'h1000, 1'b1, 64'h2500); // 10
    update(64'h1100, 1'b0, 64'h7777);  lookup(64'h1000, 1'b1, 64'h2500); // no alloc
    lookup(64'h1100, 1'b0, 64'h1104);
    update(64'h1100, 1'b1, 64'h3000);
    lookup(64'h1000, 1'b0, 64'h1004);
    lookup(64'h1100, 1'b1, 64'h3000);

    // same-cycle lookup and allocate: lookup sees the old state
    step(1'b1, 64'h2040, 1'b0, 1'b1, 64'h2040, 1'b1, 64'h5000, 1'b0, 64'h2044);
    lookup(64'h2040, 1'b1, 64'h5000);

    // back-to-back lookups, including PC+4 wrap at the top of the space
    lookup(64'h2040, 1'b1, 64'h5000);
    lookup(64'h3000, 1'b0, 64'h3004);
    lookup(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0);

    // flush kills the request being registered, not the one being presented
    step(1'b1, 64'h2040, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
    idle_cycle();
    lookup(64'h2040, 1'b1, 64'h5000);
    step(1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
    idle_cycle();

    // flush does not block training: 0x1100 counter 10 -> 01
    step(1'b0, 64'h0, 1'b1, 1'b1, 64'h1100, 1'b0, 64'h0, 1'b0, 64'h0);
    lookup(64'h1100, 1'b0, 64'h1104);

    // update fields ignored without update_valid_i
    step(1'b0, 64'h0, 1'b0, 1'b0, 64'h1100, 1'b1, 64'h8888, 1'b0, 64'h0);
    lookup(64'h1100, 1'b0, 64'h1104);

    // reset while a prediction is presented and a lookup is held
    lookup(64'h2040, 1'b1, 64'h5000);
    pulse_reset();
    idle_cycle();
    lookup(64'h1100, 1'b0, 64'h1104);
    lookup(64'h2040, 1'b0, 64'h2044);
    lookup(64'h1000, 1'b0, 64'h1004);

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d predictions outstanding, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
